// File: rtl/sram_read_sequencer.sv
// Burst read sequencer for a single-port synchronous SRAM: one read per cycle,
// credit-checked capture FIFO, ready/valid output stream.
module sram_read_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              sram_en_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [RD_LAT-1:0] sr_v_r;
  logic [RD_LAT-1:0] sr_l_r;
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic              done_r;

  logic              accept_s;
  logic              issue_s;
  logic              issue_last_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              last_pop_s;
  logic              credit_ok_s;
  logic              done_nx_s;
  logic [OUT_W-1:0]  inflight_s;
  logic [OUT_W-1:0]  outstanding_s;

  // Reads still in the SRAM pipeline: population count of the valid shift register.
  always_comb begin
    inflight_s = {OUT_W{1'b0}};
    for (int k = 0; k < RD_LAT; k++) begin
      inflight_s = inflight_s + OUT_W'(sr_v_r[k]);
    end
  end

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign outstanding_s = inflight_s + OUT_W'(fifo_cnt_r);
  assign credit_ok_s   = (outstanding_s < OUT_W'(FIFO_DEPTH));

  assign accept_s     = (state_r == S_IDLE) & cmd_valid_i;
  assign issue_s      = (state_r == S_ISSUE) & credit_ok_s;
  assign issue_last_s = issue_s & (remaining_r == LEN_W'(1));
  assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
  assign push_s       = sr_v_r[RD_LAT-1];
  assign pop_s        = valid_o & ready_i;
  assign last_pop_s   = pop_s & (fifo_cnt_r == CNT_W'(1));

  assign cmd_ready_o = (state_r == S_IDLE);
  assign busy_o      = (state_r != S_IDLE);
  assign sram_en_o   = issue_s;
  assign sram_addr_o = cur_addr_r;
  assign valid_o     = ~fifo_empty_s;
  assign data_o      = fifo_data_r[rd_ptr_r];
  assign last_o      = valid_o & fifo_last_r[rd_ptr_r];
  assign done_o      = done_r;

  // Next-state and completion decode.
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == {LEN_W{1'b0}}) begin
            state_nx_s = S_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = S_ISSUE;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_last_s) begin
          state_nx_s = S_DRAIN;
        end else begin
          state_nx_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Leave on the cycle the final word is handed off, so done lands one cycle later.
        if ((inflight_s == {OUT_W{1'b0}}) && (fifo_empty_s || last_pop_s)) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        done_nx_s  = 1'b0;
      end
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Command address / word counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr_r  <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      cur_addr_r  <= cmd_addr_i;
      remaining_r <= cmd_len_i;
    end else if (issue_s) begin
      cur_addr_r  <= cur_addr_r + ADDR_W'(1);
      remaining_r <= remaining_r - LEN_W'(1);
    end
  end

  // In-flight {valid, last} tracker aligned with the SRAM read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_v_r <= {RD_LAT{1'b0}};
      sr_l_r <= {RD_LAT{1'b0}};
    end else begin
      sr_v_r[0] <= issue_s;
      sr_l_r[0] <= issue_last_s;
      for (int k = 1; k < RD_LAT; k++) begin
        sr_v_r[k] <= sr_v_r[k-1];
        sr_l_r[k] <= sr_l_r[k-1];
      end
    end
  end

  // Capture FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      fifo_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= sram_rdata_i;
        fifo_last_r[wr_ptr_r] <= sr_l_r[RD_LAT-1];
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Directed scoreboard bench for sram_read_sequencer; SRAM model returns word i at address i.
module tb_sram_read_sequencer;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          valid;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic          last;
  logic          busy;
  logic          done;

  sram_read_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(2), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .sram_en_o(sram_en), .sram_addr_o(sram_addr), .sram_rdata_i(sram_rdata),
    .valid_o(valid), .ready_i(ready), .data_o(data), .last_o(last),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage SRAM model; junk when no read was issued.
  logic [DW-1:0] p1 = '0;
  logic [DW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= sram_en ? DW'(sram_addr) : 32'hDEAD_BEEF;
    p2 <= p1;
  end
  assign sram_rdata = p2;

  bit bp_mode = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    ready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: actual=event expected=none", nm);
  endtask

  // Scoreboard state shared between driver and monitor
  logic [32:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            done_q[$];
  int outst = 0, max_outst = 0, issued = 0, cur_len = 0;
  int last_cnt = 0, busy_cnt = 0, en_cnt = 0, valid_cnt = 0, en_stall_cnt = 0, t_first = 0;
  bit first_seen = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [32:0]   e_w;
  logic [AW-1:0] a_w;

  always @(negedge clk) begin
    if (!rstn) begin
      outst = 0; issued = 0; cur_len = 0; prev_stall = 1'b0; prev_done = 1'b0;
    end else begin
      if (busy) begin
        chk("sram_en_credit", {31'd0, sram_en}, {31'd0, (issued < cur_len) && (outst < DEP)});
        busy_cnt++;
        if ((issued < cur_len) && !sram_en) en_stall_cnt++;
      end
      if (sram_en) begin
        en_cnt++;
        if (addr_q.size() == 0) fail("unexpected_read");
        else begin
          a_w = addr_q.pop_front();
          chk("sram_addr", {22'd0, sram_addr}, {22'd0, a_w});
        end
        issued++;
      end
      if (valid) begin
        valid_cnt++;
        if (!first_seen) begin t_first = cyc; first_seen = 1'b1; end
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, valid}, 32'd1);
        chk("stall_data", data, prev_data);
        chk("stall_last", {31'd0, last}, {31'd0, prev_last});
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          e_w = exp_q.pop_front();
          chk("data", data, e_w[31:0]);
          chk("last", {31'd0, last}, {31'd0, e_w[32]});
        end
        if (last) last_cnt++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
      if (done) begin
        done_q.push_back(cyc);
        if (prev_done) fail("done_width");
      end
      prev_done = done;
      if (cmd_valid && cmd_ready) begin
        cur_len = int'(cmd_len); issued = 0; first_seen = 1'b0;
      end
      outst = outst + int'(sram_en) - int'(valid && ready);
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] ad, input int l, output int t_acc);
    logic [AW-1:0] a;
    bit ok;
    for (int i = 0; i < l; i++) begin
      a = AW'(ad + AW'(i));
      addr_q.push_back(a);
      exp_q.push_back({(i == l - 1), DW'(a)});
    end
    cmd_valid = 1'b1;
    cmd_addr  = ad;
    cmd_len   = LW'(l);
    ok = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t_acc = cyc; ok = 1'b1; break; end
    end
    if (!ok) fail("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (done_q.size() > 0) begin t = done_q.pop_front(); break; end
    end
    if (t < 0) fail("done_timeout");
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_last"}, {31'd0, last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_sram_addr"}, {22'd0, sram_addr}, 32'd0);
    chk({tag, "_data"}, data, 32'd0);
  endtask

  task automatic basic_burst(input string tag);
    int ta, td;
    last_cnt = 0;
    send_cmd(10'h010, 5, ta);
    wait_done(td);
    chk({tag, "_first_valid_lat"}, t_first - ta, 32'd4);
    chk({tag, "_done_lat"}, td - ta, 32'd9);
    chk({tag, "_last_count"}, last_cnt, 32'd1);
    chk({tag, "_all_words"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int ta, tb2, td;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    basic_burst("basic");

    // 1-of-3 downstream ready
    bp_mode = 1'b1; max_outst = 0; en_stall_cnt = 0;
    send_cmd(10'h040, 16, ta);
    wait_done(td);
    bp_mode = 1'b0;
    chk("bp_max_outstanding", max_outst, 32'd4);
    chk("bp_en_stalled", {31'd0, en_stall_cnt > 0}, 32'd1);
    chk("bp_all_words", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk); #1;

    send_cmd(10'h3FE, 4, ta);
    wait_done(td);
    chk("wrap_done_lat", td - ta, 32'd8);
    chk("wrap_all_reads", addr_q.size(), 32'd0);

    busy_cnt = 0; en_cnt = 0;
    send_cmd(10'h020, 0, ta);
    wait_done(td);
    chk("zero_done_lat", td - ta, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("zero_busy_cycles", busy_cnt, 32'd0);
    chk("zero_reads", en_cnt, 32'd0);

    send_cmd(10'h050, 0, ta);
    send_cmd(10'h060, 1, tb2);
    chk("zero_followup_accept", tb2 - ta, 32'd1);
    wait_done(td);
    chk("zero_followup_done0", td - ta, 32'd1);
    wait_done(td);
    chk("zero_followup_done1", td - tb2, 32'd5);

    last_cnt = 0;
    send_cmd(10'h000, 3, ta);
    send_cmd(10'h100, 2, tb2);
    chk("b2b_accept_lat", tb2 - ta, 32'd7);
    wait_done(td);
    chk("b2b_accept_in_done", tb2, td);
    wait_done(td);
    chk("b2b_done2_lat", td - tb2, 32'd6);
    chk("b2b_last_count", last_cnt, 32'd2);

    // Reset in DRAIN with two reads still in the SRAM pipeline
    send_cmd(10'h010, 5, ta);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_en", {31'd0, sram_en}, 32'd0);
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete(); addr_q.delete();
    valid_cnt = 0;
    repeat (6) @(posedge clk); #1;
    chk("rst_no_stray_valid", valid_cnt, 32'd0);
    chk("rst_no_done", done_q.size(), 32'd0);

    basic_burst("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/sram_read_sequencer.md
# sram_read_sequencer

Sequences burst reads from a single-port synchronous SRAM and streams the returned words to the downstream ready/valid datapath (the comparison path). Each accepted command (start address, word count) becomes one SRAM read per cycle at fixed read latency. An internal credit-checked capture FIFO guarantees that no returned word is lost while the downstream stalls. The block sits between the command source and the SRAM, and its output feeds the comparison-side buffer.

## Interface
- ADDR_W, 10, SRAM address width
- DATA_W, 32, SRAM / stream data width
- LEN_W, 8, command word-count width
- RD_LAT, 2, SRAM read latency in cycles (>= 1)
- FIFO_DEPTH, 4, capture FIFO entries (power of two); must be >= RD_LAT+2 for one word/cycle sustained throughput

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when both high
- cmd_addr_i  in  ADDR_W  start address
- cmd_len_i  in  LEN_W  number of words to read (0 is legal)
- sram_en_o  out  1  read enable, one read per high cycle
- sram_addr_o  out  ADDR_W  read address
- sram_rdata_i  in  DATA_W  read data, valid RD_LAT cycles after sram_en_o
- valid_o  out  1  output word valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_W  output word
- last_o  out  1  final word of the current command (qualified by valid_o)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when a command has fully completed

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready_o = 1. On cmd_valid_i, latch cur_addr = cmd_addr_i and remaining = cmd_len_i.
  - If cmd_len_i == 0: stay in IDLE and pulse done_o next cycle. No SRAM access occurs.
  - Otherwise go to ISSUE.
- ISSUE: sram_en_o = (inflight + fifo_count < FIFO_DEPTH). This is combinational from registered state. A pop in the same cycle does not grant credit.
  - On each issue: sram_addr_o = cur_addr, cur_addr++ (wraps mod 2^ADDR_W), remaining--.
  - The issue that takes remaining to 0 moves the FSM to DRAIN and marks that read as last.
- In-flight tracking: an RD_LAT-deep shift register of {valid, last} bits.
  - When the head bit exits valid, sram_rdata_i plus the last flag are pushed into the FIFO in that cycle.
  - Overflow is impossible by the credit rule. The bench asserts this.
- Output: valid_o = FIFO non-empty, and data_o/last_o come from the FIFO head. Pop on valid_o & ready_i.
  - data_o and last_o hold stable while valid_o & ~ready_i.
- DRAIN: wait until inflight == 0, the FIFO is empty and the last word has been popped. Then go to IDLE and pulse done_o in the following cycle.
- cmd_ready_o = 0 in ISSUE and DRAIN. Commands never overlap, and words of one command stay strictly in address order.

## Timing
- Reset values:
  - cmd_ready_o = 1.
  - sram_en_o, valid_o, last_o, busy_o, done_o = 0.
  - sram_addr_o, data_o = 0.
  - FIFO, counters and shift register are cleared.
- Command accepted in cycle T: first sram_en_o in T+1; first data on sram_rdata_i in T+1+RD_LAT; first valid_o in T+2+RD_LAT.
- With FIFO_DEPTH >= RD_LAT+2 and ready_i held high: N words leave on consecutive cycles.
  - Last handshake is at T+1+RD_LAT+N.
  - done_o fires at T+2+RD_LAT+N, and the next command can be accepted in that same cycle.
- Zero-length command: done_o at T+1, with cmd_ready_o also high at T+1.
- Downstream stall: issue stops once outstanding reaches FIFO_DEPTH. Issue resumes the cycle after a pop frees a credit.
- Reset mid-operation: everything returns to reset values. SRAM data returning after reset release is ignored because the shift register was cleared. No done_o is produced for the aborted command.
- done_o is exactly one cycle wide. busy_o covers ISSUE and DRAIN only.

## Test plan
- Basic burst: SRAM[i] = i, cmd addr 0x010, len 5, ready_i = 1. Expect data 0x10..0x14 on consecutive cycles, first valid_o at T+4, last_o only on 0x14, done_o at T+9.
- Backpressure: len 16, ready_i toggles 1-of-3 cycles. Expect:
  - Outstanding never exceeds 4.
  - No word is dropped or duplicated.
  - data_o is stable during stalls.
  - sram_en_o goes low when credits are exhausted.
- Address wrap: addr 0x3FE, len 4. Expect reads at 0x3FE, 0x3FF, 0x000, 0x001, in that order.
- Zero length: len 0. Expect no sram_en_o, done_o at T+1, busy_o never high. A follow-up command at T+1 is accepted.
- Back-to-back commands: (0x000, 3) then (0x100, 2) held valid. Expect:
  - The second is accepted only in the done_o cycle of the first.
  - Output order is 0..2 then 0x100..0x101.
  - last_o is asserted twice.
- Reset mid-burst: assert rstn low during DRAIN with 2 words in flight. Expect all outputs at reset values, no stray valid_o after release, and a new command behaving as in the basic burst.
